// File: rtl/clk_pkg.sv
// Shared clock constants and the period-meter state type for the digital-clock top level.
package clk_pkg;

    localparam int unsigned SOURCE_CLOCK      = 100_000_000;
    localparam int unsigned DISPLAY_SCAN_FREQ = 400;
    localparam int unsigned SECONDS_FREQ      = 1;

    typedef enum logic {
        StIdle,
        StMeasure
    } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, plus one-cycle rise/fall pulses.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= i_async;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s3 only delays the synchronized level for edge detection.
    assign o_level = s2_q;
    assign o_rise  = s2_q & ~s3_q;
    assign o_fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input in i_clk cycles, with lock and timeout flags.
module clk_period_meter
    import clk_pkg::*;
#(
    parameter int unsigned SOURCE_CLOCK = clk_pkg::SOURCE_CLOCK,
    parameter int unsigned EXP_FREQ     = DISPLAY_SCAN_FREQ,
    parameter int unsigned EXP_PERIOD   = SOURCE_CLOCK / EXP_FREQ,
    parameter int unsigned TOL_CNT      = 250,
    parameter int unsigned TIMEOUT_CNT  = 1_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);

    // Lower bound clamps at zero so a loose tolerance cannot wrap.
    localparam int unsigned TOL_LO_INT = (EXP_PERIOD > TOL_CNT) ? (EXP_PERIOD - TOL_CNT) : 0;
    localparam int unsigned TOL_HI_INT = EXP_PERIOD + TOL_CNT;

    localparam logic [CNT_W-1:0] TOL_LO      = CNT_W'(TOL_LO_INT);
    localparam logic [CNT_W-1:0] TOL_HI      = CNT_W'(TOL_HI_INT);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic sig_level;
    logic sig_rise;
    logic unused_fall;

    sync_edge_detect u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_sig),
        .o_level (sig_level),
        .o_rise  (sig_rise),
        .o_fall  (unused_fall)
    );

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             in_tol_prev_q, in_tol_prev_d;
    logic             in_tol;

    assign in_tol = (cnt_q >= TOL_LO) && (cnt_q <= TOL_HI);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hcnt_d        = hcnt_q;
        period_d      = period_q;
        high_d        = high_q;
        valid_d       = 1'b0;
        locked_d      = locked_q;
        timeout_d     = timeout_q;
        in_tol_prev_d = in_tol_prev_q;

        unique case (state_q)
            StIdle: begin
                // First edge after reset or timeout has no preceding period to report.
                if (sig_rise) begin
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    timeout_d = 1'b0;
                    state_d   = StMeasure;
                end
            end
            StMeasure: begin
                if (sig_rise) begin
                    period_d      = cnt_q;
                    high_d        = hcnt_q;
                    valid_d       = 1'b1;
                    cnt_d         = CNT_ONE;
                    hcnt_d        = CNT_ONE;
                    timeout_d     = 1'b0;
                    locked_d      = in_tol & in_tol_prev_q;
                    in_tol_prev_d = in_tol;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    state_d       = StIdle;
                    timeout_d     = 1'b1;
                    locked_d      = 1'b0;
                    in_tol_prev_d = 1'b0;
                end else begin
                    cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
                    hcnt_d = (sig_level && (hcnt_q != '1)) ? hcnt_q + CNT_ONE : hcnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            hcnt_q        <= '0;
            period_q      <= '0;
            high_q        <= '0;
            valid_q       <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
            in_tol_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hcnt_q        <= hcnt_d;
            period_q      <= period_d;
            high_q        <= high_d;
            valid_q       <= valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
            in_tol_prev_q <= in_tol_prev_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_locked  = locked_q;
    assign o_timeout = timeout_q;

endmodule
